// File: rtl/device_uart.sv
// Memory-mapped 8N1 UART: STATUS/TXDATA/RXDATA/DIVISOR registers, TX/RX FIFOs, reads return 1 cycle later.
// TXDATA writes to a full FIFO are dropped (tx_dropped); RX bytes arriving into a full FIFO are dropped (rx_overrun).

module device_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module device_uart #(
  parameter int TX_FIFO_DEPTH   = 8,
  parameter int RX_FIFO_DEPTH   = 8,
  parameter int DEFAULT_DIVISOR = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  device_addr,
  input  logic        device_write_en,
  input  logic        device_read_en,
  input  logic [15:0] device_data_out,
  output logic [15:0] device_data_in,
  output logic        uart_tx,
  input  logic        uart_rx
);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  localparam logic [9:0] ADDR_STATUS  = 10'h000;
  localparam logic [9:0] ADDR_TXDATA  = 10'h001;
  localparam logic [9:0] ADDR_RXDATA  = 10'h002;
  localparam logic [9:0] ADDR_DIVISOR = 10'h003;

  logic [15:0] divisor;
  logic [15:0] div_m1;
  logic [15:0] half_m1;
  logic        tx_dropped, rx_overrun, framing_err;

  logic        tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]  tx_head;
  logic        rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]  rx_head;

  logic        wr_tx, wr_div, rd_status;
  logic [15:0] status;
  logic [15:0] rd_mux;

  assign wr_tx     = device_write_en && (device_addr == ADDR_TXDATA);
  assign wr_div    = device_write_en && (device_addr == ADDR_DIVISOR);
  assign rd_status = device_read_en  && (device_addr == ADDR_STATUS);
  assign rx_pop    = device_read_en  && (device_addr == ADDR_RXDATA) && !rx_empty;
  assign tx_push   = wr_tx && !tx_full;
  assign div_m1    = divisor - 16'd1;
  assign half_m1   = {1'b0, divisor[15:1]} - 16'd1;

  device_uart_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .push_dat(device_data_out[7:0]),
    .pop(tx_pop), .head_dat(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // ---------------- TX path ----------------
  tx_state_t   tx_state, tx_state_nxt;
  logic [15:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]  tx_bit, tx_bit_nxt;
  logic [7:0]  tx_shift, tx_shift_nxt;
  logic        tx_line, tx_line_nxt;
  logic        tx_idle;

  assign uart_tx = tx_line;
  assign tx_idle = tx_empty && (tx_state == TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tx_line  <= tx_line_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = (tx_cnt != 16'd0) ? tx_cnt - 16'd1 : tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_line_nxt  = tx_line;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_nxt = 1'b1;
        if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_state_nxt = TX_START;
          tx_line_nxt  = 1'b0;
          tx_cnt_nxt   = div_m1;
          tx_shift_nxt = tx_head;
        end
      end
      TX_START: begin
        if (tx_cnt == 16'd0) begin
          tx_state_nxt = TX_DATA;
          tx_line_nxt  = tx_shift[0];
          tx_cnt_nxt   = div_m1;
          tx_bit_nxt   = 3'd0;
        end
      end
      TX_DATA: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_nxt = div_m1;
          if (tx_bit == 3'd7) begin
            tx_state_nxt = TX_STOP;
            tx_line_nxt  = 1'b1;
          end else begin
            tx_bit_nxt   = tx_bit + 3'd1;
            tx_shift_nxt = {1'b0, tx_shift[7:1]};
            tx_line_nxt  = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == 16'd0) begin
          // Chain straight into the next START so back-to-back frames have no idle gap.
          if (!tx_empty) begin
            tx_pop       = 1'b1;
            tx_state_nxt = TX_START;
            tx_line_nxt  = 1'b0;
            tx_cnt_nxt   = div_m1;
            tx_shift_nxt = tx_head;
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // ---------------- RX path ----------------
  rx_state_t   rx_state, rx_state_nxt;
  logic [15:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]  rx_bit, rx_bit_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic        rx_sync1, rx_sync2, rx_prev;
  logic        fr_set;

  device_uart_fifo #(.DEPTH(RX_FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_dat(rx_shift),
    .pop(rx_pop), .head_dat(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync1 <= uart_rx;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = (rx_cnt != 16'd0) ? rx_cnt - 16'd1 : rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_push      = 1'b0;
    fr_set       = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync2 && rx_prev) begin
          rx_state_nxt = RX_START;
          rx_cnt_nxt   = half_m1;
        end
      end
      RX_START: begin
        if (rx_cnt == 16'd0) begin
          if (rx_sync2) begin
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_state_nxt = RX_DATA;
            rx_cnt_nxt   = div_m1;
            rx_bit_nxt   = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == 16'd0) begin
          rx_shift_nxt = {rx_sync2, rx_shift[7:1]};
          rx_cnt_nxt   = div_m1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
          else                rx_bit_nxt   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == 16'd0) begin
          if (rx_sync2) begin
            rx_push      = 1'b1;
            rx_state_nxt = RX_IDLE;
          end else begin
            fr_set       = 1'b1;
            rx_state_nxt = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        if (rx_sync2) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------- Registers and read port ----------------
  assign status = {10'd0, tx_dropped, framing_err, rx_overrun, !rx_empty, tx_idle, tx_full};

  always_comb begin
    rd_mux = '0;
    case (device_addr)
      ADDR_STATUS:  rd_mux = status;
      ADDR_RXDATA:  rd_mux = rx_empty ? 16'd0 : {8'h00, rx_head};
      ADDR_DIVISOR: rd_mux = divisor;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divisor        <= 16'(DEFAULT_DIVISOR);
      device_data_in <= '0;
      tx_dropped     <= 1'b0;
      rx_overrun     <= 1'b0;
      framing_err    <= 1'b0;
    end else begin
      if (wr_div) divisor <= (device_data_out < 16'd2) ? 16'd2 : device_data_out;
      if (device_read_en) device_data_in <= rd_mux;
      // A new event on the clearing edge is kept, since the read captured the old value.
      tx_dropped  <= (tx_dropped  && !rd_status) || (wr_tx && tx_full);
      rx_overrun  <= (rx_overrun  && !rd_status) || (rx_push && rx_full && !rx_pop);
      framing_err <= (framing_err && !rd_status) || fr_set;
    end
  end
endmodule

// File: tb/tb_device_uart.sv
// Randomized self-checking bench for device_uart with a queue-based reference model and a line-level TX decoder.
`timescale 1ns/1ps
module tb_device_uart;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  device_addr;
  logic        device_write_en;
  logic        device_read_en;
  logic [15:0] device_data_out;
  logic [15:0] device_data_in;
  logic        uart_tx;
  logic        uart_rx;

  int checks = 0;
  int errors = 0;

  logic [7:0] mon_q[$];
  logic [7:0] mon_byte;
  int         mon_div = 16;
  bit         mon_en = 1'b0;
  int         mon_stop_err = 0;

  always #5 clk = ~clk;

  device_uart #(.TX_FIFO_DEPTH(8), .RX_FIFO_DEPTH(8), .DEFAULT_DIVISOR(16)) dut (
    .clk(clk), .reset(reset), .device_addr(device_addr),
    .device_write_en(device_write_en), .device_read_en(device_read_en),
    .device_data_out(device_data_out), .device_data_in(device_data_in),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  // Independent line decoder: sample mid-bit after seeing a start bit.
  always begin
    @(negedge clk);
    if (mon_en && uart_tx === 1'b0) begin
      repeat (mon_div / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (mon_div) @(negedge clk);
        mon_byte[i] = uart_tx;
      end
      repeat (mon_div) @(negedge clk);
      if (uart_tx !== 1'b1) mon_stop_err++;
      mon_q.push_back(mon_byte);
    end
  end

  // Bus tasks are entered and left on a negedge.
  task automatic bus_write(input logic [9:0] a, input logic [15:0] d);
    device_addr = a; device_data_out = d; device_write_en = 1'b1;
    @(negedge clk);
    device_write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [15:0] d);
    device_addr = a; device_read_en = 1'b1;
    @(negedge clk);
    device_read_en = 1'b0;
    d = device_data_in;
  endtask

  task automatic send_frame(input logic [7:0] b, input int d, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (d) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (2 * d) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] r;
    reset = 1'b1; device_addr = '0; device_write_en = 1'b0; device_read_en = 1'b0;
    device_data_out = '0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    checks++; if (device_data_in !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", device_data_in); end
    reset = 1'b0;
    @(negedge clk);
    bus_read(10'h000, r);
    checks++; if (r !== 16'h0002) begin errors++; $display("FAIL reset_status got %h want 0002", r); end
    bus_read(10'h003, r);
    checks++; if (r !== 16'd16) begin errors++; $display("FAIL reset_divisor got %0d want 16", r); end
    bus_read(10'h002, r);
    checks++; if (r !== 16'h0) begin errors++; $display("FAIL empty_rxdata got %h want 0000", r); end
    bus_read(10'h1F0, r);
    checks++; if (r !== 16'h0) begin errors++; $display("FAIL unmapped got %h want 0000", r); end
  endtask

  task automatic test_tx_frame(input int d, input logic [7:0] b);
    logic [9:0] bits;
    logic [15:0] r;
    int bad = 0;
    bits = {1'b1, b, 1'b0};
    bus_write(10'h003, 16'(d));
    bus_write(10'h001, {8'h00, b});
    for (int i = 0; i < 10 * d; i++) begin
      @(negedge clk);
      if (uart_tx !== bits[i / d]) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tx_wave byte %h div %0d bad_cycles %0d want 0", b, d, bad); end
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_idle_line got %b want 1", uart_tx); end
    bus_read(10'h000, r);
    checks++; if (r !== 16'h0002) begin errors++; $display("FAIL tx_done_status got %h want 0002", r); end
  endtask

  task automatic test_rx_single();
    logic [15:0] r;
    logic [7:0] b;
    bus_write(10'h003, 16'd4);
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h3C : 8'($urandom);
      send_frame(b, 4, 1'b1);
      bus_read(10'h000, r);
      checks++; if (r !== 16'h0006) begin errors++; $display("FAIL rx_status got %h want 0006", r); end
      bus_read(10'h002, r);
      checks++; if (r !== {8'h00, b}) begin errors++; $display("FAIL rx_data got %h want %h", r, {8'h00, b}); end
      bus_read(10'h000, r);
      checks++; if (r !== 16'h0002) begin errors++; $display("FAIL rx_after_status got %h want 0002", r); end
    end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] q[$];
    logic [15:0] r, exp;
    bit ovr = 1'b0;
    logic [7:0] b;
    for (int k = 0; k < 9; k++) begin
      b = 8'($urandom);
      send_frame(b, 4, 1'b1);
      if (q.size() < 8) q.push_back(b); else ovr = 1'b1;
    end
    exp = 16'h0006 | (ovr ? 16'h0008 : 16'h0000);
    bus_read(10'h000, r);
    checks++; if (r !== exp) begin errors++; $display("FAIL ovr_status got %h want %h", r, exp); end
    while (q.size() > 0) begin
      b = q.pop_front();
      bus_read(10'h002, r);
      checks++; if (r !== {8'h00, b}) begin errors++; $display("FAIL ovr_data got %h want %h", r, {8'h00, b}); end
    end
    bus_read(10'h000, r);
    checks++; if (r !== 16'h0002) begin errors++; $display("FAIL ovr_cleared got %h want 0002", r); end
    bus_read(10'h002, r);
    checks++; if (r !== 16'h0) begin errors++; $display("FAIL ovr_empty_read got %h want 0000", r); end
  endtask

  task automatic test_framing();
    logic [15:0] r;
    logic [7:0] b;
    send_frame(8'($urandom), 4, 1'b0);
    bus_read(10'h000, r);
    checks++; if (r !== 16'h0012) begin errors++; $display("FAIL frame_status got %h want 0012", r); end
    bus_read(10'h000, r);
    checks++; if (r !== 16'h0002) begin errors++; $display("FAIL frame_cleared got %h want 0002", r); end
    b = 8'($urandom);
    send_frame(b, 4, 1'b1);
    bus_read(10'h002, r);
    checks++; if (r !== {8'h00, b}) begin errors++; $display("FAIL frame_recover got %h want %h", r, {8'h00, b}); end
    bus_write(10'h003, 16'd1);
    bus_read(10'h003, r);
    checks++; if (r !== 16'd2) begin errors++; $display("FAIL div_clamp1 got %0d want 2", r); end
    bus_write(10'h003, 16'd0);
    bus_read(10'h003, r);
    checks++; if (r !== 16'd2) begin errors++; $display("FAIL div_clamp0 got %0d want 2", r); end
  endtask

  task automatic test_simul_rw();
    logic [15:0] r;
    bus_write(10'h003, 16'd5);
    device_addr = 10'h003; device_data_out = 16'd9;
    device_write_en = 1'b1; device_read_en = 1'b1;
    @(negedge clk);
    device_write_en = 1'b0; device_read_en = 1'b0;
    checks++; if (device_data_in !== 16'd5) begin errors++; $display("FAIL simul_read got %0d want 5", device_data_in); end
    bus_read(10'h003, r);
    checks++; if (r !== 16'd9) begin errors++; $display("FAIL simul_write got %0d want 9", r); end
  endtask

  task automatic test_tx_full();
    logic [7:0] exp_q[$];
    logic [7:0] b, got;
    logic [15:0] r;
    int cnt = 0;
    int budget = 0;
    bus_write(10'h003, 16'd16);
    mon_div = 16; mon_q.delete(); mon_stop_err = 0; mon_en = 1'b1;
    b = 8'($urandom);
    exp_q.push_back(b);
    bus_write(10'h001, {8'h00, b});
    repeat (20) @(negedge clk);
    // Transmitter is busy with the first byte, so the FIFO absorbs up to its depth.
    for (int k = 0; k < 9; k++) begin
      b = 8'($urandom);
      if (cnt < 8) begin exp_q.push_back(b); cnt++; end
      bus_write(10'h001, {8'h00, b});
    end
    bus_read(10'h000, r);
    checks++; if (r !== 16'h0021) begin errors++; $display("FAIL full_status got %h want 0021", r); end
    while (mon_q.size() < exp_q.size() && budget < 2500) begin
      @(negedge clk);
      budget++;
    end
    repeat (300) @(negedge clk);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL full_frames got %0d want %0d", mon_q.size(), exp_q.size());
    end
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      got = mon_q.pop_front(); b = exp_q.pop_front();
      checks++; if (got !== b) begin errors++; $display("FAIL full_byte got %h want %h", got, b); end
    end
    checks++; if (mon_stop_err != 0) begin errors++; $display("FAIL full_stopbits got %0d want 0", mon_stop_err); end
    mon_en = 1'b0;
    bus_read(10'h000, r);
    checks++; if (r !== 16'h0002) begin errors++; $display("FAIL full_after got %h want 0002", r); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    bus_write(10'h003, 16'd8);
    bus_write(10'h001, 16'h0000);
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_tx_active got %b want 0", uart_tx); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx got %b want 1", uart_tx); end
    reset = 1'b0; uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    bus_read(10'h003, r);
    checks++; if (r !== 16'd16) begin errors++; $display("FAIL mid_divisor got %0d want 16", r); end
    bus_read(10'h000, r);
    checks++; if (r !== 16'h0002) begin errors++; $display("FAIL mid_status got %h want 0002", r); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_line got %b want 1", uart_tx); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_tx_frame(4, 8'hA5);
    test_tx_frame(2, 8'($urandom));
    test_tx_frame(int'($urandom_range(3, 7)), 8'($urandom));
    test_rx_single();
    test_rx_overrun();
    test_framing();
    test_simul_rw();
    test_tx_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
